// File: rtl/button_pkg.sv
// Shared types, timing defaults and counter helpers for the button event decoder.
package button_pkg;

  localparam int CNT_W = 12;

  localparam int LONG_PRESS_MS_DEF   = 1000;
  localparam int DOUBLE_CLICK_MS_DEF = 250;
  localparam int REPEAT_MS_DEF       = 200;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE           = 3'd0;
  localparam state_t ST_PRESSED        = 3'd1;
  localparam state_t ST_LONG_HELD      = 3'd2;
  localparam state_t ST_WAIT_SECOND    = 3'd3;
  localparam state_t ST_SECOND_PRESSED = 3'd4;

  // Saturating increment so long idle/hold periods never wrap the counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/double-click pulses.
// Optional macro BUTTON_REPEAT_EN enables long_press auto-repeat while held.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_PRESS_MS   = LONG_PRESS_MS_DEF,
  parameter int DOUBLE_CLICK_MS = DOUBLE_CLICK_MS_DEF,
  parameter int REPEAT_MS       = REPEAT_MS_DEF
) (
  input  logic clk_1KHz,
  input  logic reset_n,
  input  logic debounced_input,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_MS - 1);
  localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DOUBLE_CLICK_MS - 1);

  if ((LONG_PRESS_MS < 2) || (LONG_PRESS_MS > 4095) ||
      (DOUBLE_CLICK_MS < 2) || (DOUBLE_CLICK_MS > 4095) ||
      (REPEAT_MS < 2) || (REPEAT_MS > 4095)) begin : g_param_range
    $error("button_event_decoder: timing parameters must lie in 2..4095");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;

`ifdef BUTTON_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MS - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  // Edge detection, event FSM and the shared per-state counter.
  always_comb begin
    held_d    = debounced_input;
    press_d   = debounced_input & ~held_q;
    release_d = ~debounced_input & held_q;
    state_d   = state_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
    dbl_d     = 1'b0;
`ifdef BUTTON_REPEAT_EN
    rep_d     = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (press_d) state_d = ST_PRESSED;
        else         state_d = ST_IDLE;
      end
      ST_PRESSED: begin
        if (!debounced_input) begin
          state_d = ST_WAIT_SECOND;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_LONG_HELD: begin
        if (!debounced_input) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LONG_HELD;
`ifdef BUTTON_REPEAT_EN
          if (rep_q == REP_LAST) long_d = 1'b1;
          else                   rep_d  = sat_inc(rep_q);
`endif
        end
      end
      ST_WAIT_SECOND: begin
        // A press on the timeout cycle itself still counts as a double click.
        if (debounced_input) begin
          dbl_d   = 1'b1;
          state_d = ST_SECOND_PRESSED;
        end else if (cnt_q == DC_LAST) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_SECOND;
        end
      end
      ST_SECOND_PRESSED: begin
        if (!debounced_input) state_d = ST_IDLE;
        else                  state_d = ST_SECOND_PRESSED;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = sat_inc(cnt_q);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_1KHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      dbl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      dbl_q     <= dbl_d;
    end
  end

`ifdef BUTTON_REPEAT_EN
  // Auto-repeat period counter, restarted at every long_press pulse.
  always_ff @(posedge clk_1KHz or negedge reset_n) begin
    if (!reset_n) rep_q <= '0;
    else          rep_q <= rep_d;
  end
`endif

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign double_click  = dbl_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed and randomized checks of button_event_decoder against a timestamp-based model.
module tb_button_event_decoder;

  localparam int LONG_MS = 1000;
  localparam int DC_MS   = 250;
  localparam int REP_MS  = 200;
`ifdef BUTTON_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_FIRST = 1, P_LONG = 2, P_GAP = 3, P_SECOND = 4;

  logic clk_1KHz        = 1'b0;
  logic reset_n         = 1'b1;
  logic debounced_input = 1'b0;
  logic press_pulse, release_pulse, short_press, long_press, double_click, held;

  always #5 clk_1KHz = ~clk_1KHz;

  button_event_decoder #(
    .LONG_PRESS_MS  (LONG_MS),
    .DOUBLE_CLICK_MS(DC_MS),
    .REPEAT_MS      (REP_MS)
  ) dut (
    .clk_1KHz       (clk_1KHz),
    .reset_n        (reset_n),
    .debounced_input(debounced_input),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse),
    .short_press    (short_press),
    .long_press     (long_press),
    .double_click   (double_click),
    .held           (held)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0;

  // Reference model: phase plus timestamps of the relevant edges.
  int ph = P_IDLE, t_press = 0, t_rel = 0, t_long = 0;
  bit m_prev = 1'b0;

  int obs_press, obs_rel, obs_short, obs_long, obs_dbl;
  int at_press, at_rel, at_short, at_long_first, at_long, at_dbl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_press = 0; obs_rel = 0; obs_short = 0; obs_long = 0; obs_dbl = 0;
    at_press = -1; at_rel = -1; at_short = -1; at_long_first = -1; at_long = -1; at_dbl = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_press"},   press_pulse,   1'b0);
    chk({tag, "_release"}, release_pulse, 1'b0);
    chk({tag, "_short"},   short_press,   1'b0);
    chk({tag, "_long"},    long_press,    1'b0);
    chk({tag, "_double"},  double_click,  1'b0);
    chk({tag, "_held"},    held,          1'b0);
  endtask

  // Drive one input level for one clock, advance the model, compare every output.
  task automatic step(input logic x);
    logic e_press, e_rel, e_short, e_long, e_dbl, e_held;
    debounced_input = x;
    @(posedge clk_1KHz);
    #1;
    cyc++;
    e_press = 1'b0; e_rel = 1'b0; e_short = 1'b0; e_long = 1'b0; e_dbl = 1'b0; e_held = 1'b0;
    if (!reset_n) begin
      ph     = P_IDLE;
      m_prev = 1'b0;
    end else begin
      e_held  = x;
      e_press = x & ~m_prev;
      e_rel   = ~x & m_prev;
      case (ph)
        P_IDLE: begin
          if (e_press) begin ph = P_FIRST; t_press = cyc; end
        end
        P_FIRST: begin
          if (!x) begin
            ph = P_GAP; t_rel = cyc;
          end else if (cyc - t_press == LONG_MS) begin
            e_long = 1'b1; ph = P_LONG; t_long = cyc;
          end
        end
        P_LONG: begin
          if (!x) ph = P_IDLE;
          else if (REP_EN && ((cyc - t_long) % REP_MS == 0)) e_long = 1'b1;
        end
        P_GAP: begin
          if (x) begin
            e_dbl = 1'b1; ph = P_SECOND;
          end else if (cyc - t_rel == DC_MS) begin
            e_short = 1'b1; ph = P_IDLE;
          end
        end
        P_SECOND: begin
          if (!x) ph = P_IDLE;
        end
        default: ph = P_IDLE;
      endcase
      m_prev = x;
    end
    chk("press_pulse",   press_pulse,   e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("short_press",   short_press,   e_short);
    chk("long_press",    long_press,    e_long);
    chk("double_click",  double_click,  e_dbl);
    chk("held",          held,          e_held);
    chk("one_event_max", ($countones({short_press, long_press, double_click}) <= 1), 1'b1);
    if (press_pulse === 1'b1)   begin obs_press++; at_press = cyc; end
    if (release_pulse === 1'b1) begin obs_rel++;   at_rel   = cyc; end
    if (short_press === 1'b1)   begin obs_short++; at_short = cyc; end
    if (double_click === 1'b1)  begin obs_dbl++;   at_dbl   = cyc; end
    if (long_press === 1'b1) begin
      if (obs_long == 0) at_long_first = cyc;
      obs_long++;
      at_long = cyc;
    end
  endtask

  initial begin
    int t0;
    int unsigned d;
    logic lvl;
    clear_obs();

    // Asynchronous reset before any clock edge.
    #1 reset_n = 1'b0;
    #1 chk_all_zero("reset_state");
    repeat (3) step(1'b0);
    reset_n = 1'b1;

    // Short press: short_press 250 cycles after release.
    clear_obs(); t0 = cyc;
    repeat (100) step(1'b1);
    repeat (300) step(1'b0);
    chk("short_press_at", at_press, t0 + 1);
    chk("short_rel_at", at_rel, t0 + 101);
    chk("short_delay", at_short - at_rel, 250);
    chk("short_count", obs_short, 1);
    chk("short_no_long", obs_long, 0);
    chk("short_no_dbl", obs_dbl, 0);

    // Long hold of 1500 cycles.
    clear_obs(); t0 = cyc;
    repeat (1500) step(1'b1);
    repeat (300) step(1'b0);
    chk("long_first_delay", at_long_first - at_press, 1000);
    chk("long_count", obs_long, REP_EN ? 3 : 1);
    chk("long_release_count", obs_rel, 1);
    chk("long_no_short", obs_short, 0);

    // Double click with a 100-cycle gap.
    clear_obs(); t0 = cyc;
    repeat (50) step(1'b1);
    repeat (100) step(1'b0);
    repeat (50) step(1'b1);
    repeat (300) step(1'b0);
    chk("dbl_at", at_dbl, t0 + 151);
    chk("dbl_count", obs_dbl, 1);
    chk("dbl_no_short", obs_short, 0);

    // Gap boundary: 249 and 250 idle cycles still double-click, 251 does not.
    for (int g = 249; g <= 251; g++) begin
      clear_obs();
      repeat (50) step(1'b1);
      repeat (g) step(1'b0);
      repeat (50) step(1'b1);
      repeat (300) step(1'b0);
      chk("gap_dbl_count", obs_dbl, (g <= 250) ? 1 : 0);
      chk("gap_short_count", obs_short, (g <= 250) ? 0 : 2);
    end

    // Reset in the middle of a hold, released with the input still high.
    clear_obs();
    repeat (500) step(1'b1);
    reset_n = 1'b0;
    #1 chk_all_zero("reset_async");
    repeat (5) step(1'b1);
    reset_n = 1'b1;
    clear_obs(); t0 = cyc;
    repeat (1100) step(1'b1);
    repeat (300) step(1'b0);
    chk("rst_press_at", at_press, t0 + 1);
    chk("rst_press_count", obs_press, 1);
    chk("rst_long_delay", at_long_first - at_press, 1000);
    chk("rst_long_count", obs_long, 1);
    chk("rst_no_short", obs_short, 0);

    // 1600-cycle hold: repeat pulses only when the feature is built in.
    clear_obs(); t0 = cyc;
    repeat (1601) step(1'b1);
    repeat (300) step(1'b0);
    chk("rep_count", obs_long, REP_EN ? 4 : 1);
    chk("rep_last_delay", at_long - at_press, REP_EN ? 1600 : 1000);

    // Randomized segments biased toward the timing boundaries.
    lvl = 1'b1;
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 4))
        0:       d = $urandom_range(1, 5);
        1:       d = $urandom_range(240, 260);
        2:       d = $urandom_range(990, 1010);
        3:       d = $urandom_range(190, 210);
        default: d = $urandom_range(1, 600);
      endcase
      repeat (d) step(lvl);
      lvl = ~lvl;
    end
    repeat (300) step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
